branch_resolver: RTL and testbench

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/branch_resolver.sv | 172 +++++++++++++++++
 tb/tb_branch_resolver.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolver.sv
// ---------------------------------------------------------------------------
// branch_resolver
//   Resolves branches and jumps in the ID stage against the prediction that
//   came with the instruction from IF. For each resolved control-flow
//   instruction it pulses a predictor update and a BTB write. On a
//   misprediction it raises flush, supplies the correct next PC, and kills
//   the wrong-path instruction that is entering ID. It also keeps counts of
//   resolutions and mispredictions.
//
//   The BTB is indexed by PC[7:0] with tag PC[15:8]. Only the write request
//   is generated here; the BTB itself lives elsewhere.
//
// Ports
//   clk, reset      : single clock; asynchronous active-high reset
//   stall           : holds the IF/ID register and blocks resolution
//   if_valid, if_pc, if_pred_taken, if_pred_target
//                   : IF-stage instruction and its prediction
//   id_is_branch, id_is_jump, id_cond, id_target
//                   : decode/evaluate results for the instruction in ID
//   is_predict      : one-cycle pulse, a branch/jump resolved (BHT update)
//   flush           : one-cycle pulse, misprediction
//   btb_write       : one-cycle pulse, write BTB entry {write_pc, pc_target}
//   write_pc        : PC of the last resolved branch/jump
//   pc_target       : resolved target of the last resolved branch/jump
//   redirect_pc     : correct next PC, valid while flush is high
//   predict_cnt     : number of resolutions (wraps)
//   flush_cnt       : number of mispredictions (wraps)
// ---------------------------------------------------------------------------
module branch_resolver #(
  parameter int unsigned WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 if_valid,
  input  logic [WORD_SIZE-1:0] if_pc,
  input  logic                 if_pred_taken,
  input  logic [WORD_SIZE-1:0] if_pred_target,
  input  logic                 id_is_branch,
  input  logic                 id_is_jump,
  input  logic                 id_cond,
  input  logic [WORD_SIZE-1:0] id_target,
  output logic                 is_predict,
  output logic                 flush,
  output logic                 btb_write,
  output logic [WORD_SIZE-1:0] write_pc,
  output logic [WORD_SIZE-1:0] pc_target,
  output logic [WORD_SIZE-1:0] redirect_pc,
  output logic [WORD_SIZE-1:0] predict_cnt,
  output logic [WORD_SIZE-1:0] flush_cnt
);

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // IF/ID pipeline payload
  typedef struct packed {
    logic                 valid;
    logic [WORD_SIZE-1:0] pc;
    logic                 pred_taken;
    logic [WORD_SIZE-1:0] pred_target;
  } ifid_t;

  state_t state_q;
  state_t state_d;

  ifid_t ifid_q;
  ifid_t ifid_d;

  logic                 resolve_c;
  logic                 actual_taken_c;
  logic [WORD_SIZE-1:0] seq_pc_c;
  logic [WORD_SIZE-1:0] actual_next_c;
  logic [WORD_SIZE-1:0] pred_next_c;
  logic                 mispredict_c;
  logic                 btb_write_c;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: FLUSH always lasts exactly one cycle, stall or not
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (mispredict_c) state_d = FLUSH;
      FLUSH:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // FSM output / resolve logic
  always_comb begin
    resolve_c      = 1'b0;
    actual_taken_c = 1'b0;
    seq_pc_c       = ifid_q.pc + WORD_SIZE'(1);
    actual_next_c  = seq_pc_c;
    pred_next_c    = seq_pc_c;
    mispredict_c   = 1'b0;
    btb_write_c    = 1'b0;

    // A jump wins when decode flags both branch and jump
    actual_taken_c = id_is_jump | (id_is_branch & id_cond);
    if (actual_taken_c) actual_next_c = id_target;
    if (ifid_q.pred_taken) pred_next_c = ifid_q.pred_target;

    if (state_q == RUN && ifid_q.valid && !stall && (id_is_branch || id_is_jump)) begin
      resolve_c    = 1'b1;
      mispredict_c = (pred_next_c != actual_next_c);
      // Only taken instructions go into the BTB, and only if the stored target is stale
      btb_write_c  = actual_taken_c &&
                     (!ifid_q.pred_taken || (ifid_q.pred_target != id_target));
    end
  end

  // IF/ID next value: load unless stalled; a misprediction kills the
  // instruction entering ID since it was fetched down the wrong path
  always_comb begin
    ifid_d = ifid_q;
    if (!stall) begin
      ifid_d.valid       = if_valid;
      ifid_d.pc          = if_pc;
      ifid_d.pred_taken  = if_pred_taken;
      ifid_d.pred_target = if_pred_target;
    end
    if (mispredict_c) ifid_d.valid = 1'b0;
  end

  // IF/ID register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_q <= '0;
    end else begin
      ifid_q <= ifid_d;
    end
  end

  // Registered pulses, resolution record, and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      is_predict  <= 1'b0;
      flush       <= 1'b0;
      btb_write   <= 1'b0;
      write_pc    <= '0;
      pc_target   <= '0;
      redirect_pc <= '0;
      predict_cnt <= '0;
      flush_cnt   <= '0;
    end else begin
      is_predict <= resolve_c;
      flush      <= mispredict_c;
      btb_write  <= btb_write_c;
      if (resolve_c) begin
        write_pc    <= ifid_q.pc;
        pc_target   <= id_target;
        predict_cnt <= predict_cnt + WORD_SIZE'(1);
      end
      if (mispredict_c) begin
        redirect_pc <= actual_next_c;
        flush_cnt   <= flush_cnt + WORD_SIZE'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// ---------------------------------------------------------------------------
// tb_branch_resolver
//   Directed scenarios followed by randomized traffic, all checked against
//   a transaction-level reference model of the resolver.
// ---------------------------------------------------------------------------
module tb_branch_resolver;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        if_valid;
  logic [15:0] if_pc;
  logic        if_pred_taken;
  logic [15:0] if_pred_target;
  logic        id_is_branch;
  logic        id_is_jump;
  logic        id_cond;
  logic [15:0] id_target;
  logic        is_predict;
  logic        flush;
  logic        btb_write;
  logic [15:0] write_pc;
  logic [15:0] pc_target;
  logic [15:0] redirect_pc;
  logic [15:0] predict_cnt;
  logic [15:0] flush_cnt;

  branch_resolver #(.WORD_SIZE(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target),
    .id_is_branch   (id_is_branch),
    .id_is_jump     (id_is_jump),
    .id_cond        (id_cond),
    .id_target      (id_target),
    .is_predict     (is_predict),
    .flush          (flush),
    .btb_write      (btb_write),
    .write_pc       (write_pc),
    .pc_target      (pc_target),
    .redirect_pc    (redirect_pc),
    .predict_cnt    (predict_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the instruction sitting in ID, whether the previous
  // cycle was a flush bubble, and the expected output values
  logic        m_valid, m_pt, m_bubble;
  logic [15:0] m_pc, m_ptgt;
  logic        e_pred, e_flush, e_btb;
  logic [15:0] e_wpc, e_tgt, e_redir, e_pcnt, e_fcnt;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".is_predict"},  16'(is_predict), 16'(e_pred));
    chk({ctx, ".flush"},       16'(flush),      16'(e_flush));
    chk({ctx, ".btb_write"},   16'(btb_write),  16'(e_btb));
    chk({ctx, ".write_pc"},    write_pc,        e_wpc);
    chk({ctx, ".pc_target"},   pc_target,       e_tgt);
    chk({ctx, ".redirect_pc"}, redirect_pc,     e_redir);
    chk({ctx, ".predict_cnt"}, predict_cnt,     e_pcnt);
    chk({ctx, ".flush_cnt"},   flush_cnt,       e_fcnt);
  endtask

  task automatic model_reset();
    m_valid = 0; m_pt = 0; m_bubble = 0; m_pc = 0; m_ptgt = 0;
    e_pred = 0; e_flush = 0; e_btb = 0;
    e_wpc = 0; e_tgt = 0; e_redir = 0; e_pcnt = 0; e_fcnt = 0;
  endtask

  // One clock: apply inputs, advance the model, check all outputs
  task automatic step(input logic st, input logic iv, input logic [15:0] ipc,
                      input logic ipt, input logic [15:0] iptgt,
                      input logic br, input logic jmp, input logic cond,
                      input logic [15:0] tgt, input string ctx);
    logic        res, tk, mis;
    logic [15:0] seq, act, prd;
    stall = st; if_valid = iv; if_pc = ipc; if_pred_taken = ipt;
    if_pred_target = iptgt; id_is_branch = br; id_is_jump = jmp;
    id_cond = cond; id_target = tgt;
    @(posedge clk);
    res = m_valid && !m_bubble && !st && (br || jmp);
    seq = m_pc + 16'd1;
    tk  = jmp || (br && cond);
    act = tk ? tgt : seq;
    prd = m_pt ? m_ptgt : seq;
    mis = res && (act != prd);
    e_pred  = res;
    e_flush = mis;
    e_btb   = res && tk && (!m_pt || (m_ptgt != tgt));
    if (res) begin e_wpc = m_pc; e_tgt = tgt; e_pcnt = e_pcnt + 16'd1; end
    if (mis) begin e_redir = act; e_fcnt = e_fcnt + 16'd1; end
    if (!st) begin m_valid = iv; m_pc = ipc; m_pt = ipt; m_ptgt = iptgt; end
    if (mis) m_valid = 0;
    m_bubble = mis;
    #1;
    check_all(ctx);
  endtask

  task automatic idle(input string ctx);
    step(0, 0, 16'h0, 0, 16'h0, 0, 0, 0, 16'h0, ctx);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    model_reset();
    check_all("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [15:0] pool [4];
    pool[0] = 16'h0010; pool[1] = 16'h0020; pool[2] = 16'h0030; pool[3] = 16'hFFFF;
    reset = 1'b1; stall = 0; if_valid = 0; if_pc = 0; if_pred_taken = 0;
    if_pred_target = 0; id_is_branch = 0; id_is_jump = 0; id_cond = 0; id_target = 0;
    model_reset();
    do_reset();

    // Jump 0x0010 -> 0x0040 predicted not-taken; the branch fetched behind it is killed
    step(0, 1, 16'h0010, 0, 16'h0000, 0, 0, 0, 16'h0, "j_load");
    step(0, 1, 16'h0011, 1, 16'h0011, 0, 1, 0, 16'h0040, "j_res");
    chk("j_flush", 16'(flush), 16'h1);
    chk("j_redirect", redirect_pc, 16'h0040);
    chk("j_btb", 16'(btb_write), 16'h1);
    chk("j_wpc", write_pc, 16'h0010);
    chk("j_fcnt", flush_cnt, 16'h0001);
    step(0, 1, 16'h0040, 0, 16'h0, 1, 0, 1, 16'h0099, "kill");
    chk("kill_pred", 16'(is_predict), 16'h0);
    chk("kill_pcnt", predict_cnt, 16'h0001);
    idle("kill_after");

    // Branch 0x0020 not taken, predicted taken to 0x0030
    step(0, 1, 16'h0020, 1, 16'h0030, 0, 0, 0, 16'h0, "bnt_load");
    step(0, 0, 16'h0, 0, 16'h0, 1, 0, 0, 16'h0030, "bnt_res");
    chk("bnt_flush", 16'(flush), 16'h1);
    chk("bnt_redirect", redirect_pc, 16'h0021);
    chk("bnt_btb", 16'(btb_write), 16'h0);
    chk("bnt_pred", 16'(is_predict), 16'h1);
    idle("bnt_bubble");

    // Correctly predicted taken branch; the following jump still resolves (FSM in RUN)
    step(0, 1, 16'h0020, 1, 16'h0030, 0, 0, 0, 16'h0, "bt_load");
    step(0, 1, 16'h0050, 1, 16'h0060, 1, 0, 1, 16'h0030, "bt_res");
    chk("bt_pred", 16'(is_predict), 16'h1);
    chk("bt_flush", 16'(flush), 16'h0);
    chk("bt_btb", 16'(btb_write), 16'h0);
    step(0, 0, 16'h0, 0, 16'h0, 0, 1, 0, 16'h0060, "bt_next");
    chk("bt_run", 16'(is_predict), 16'h1);

    // Stall three cycles with a branch in ID, then release into a misprediction
    step(0, 1, 16'h0070, 0, 16'h0, 0, 0, 0, 16'h0, "st_load");
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 16'h0123, 0, 16'h0, 1, 0, 1, 16'h0080, "st_hold");
      chk("st_nopulse", 16'({is_predict, flush, btb_write}), 16'h0);
    end
    step(0, 0, 16'h0, 0, 16'h0, 1, 0, 1, 16'h0080, "st_rel");
    chk("st_rel_flush", 16'(flush), 16'h1);
    // Asynchronous reset in the middle of the flush cycle
    #2;
    reset = 1'b1;
    #1;
    chk("rst_flush", 16'(flush), 16'h0);
    chk("rst_pcnt", predict_cnt, 16'h0);
    chk("rst_fcnt", flush_cnt, 16'h0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(0, 1, 16'hFFFF, 1, 16'h0005, 1, 0, 1, 16'h0044, "post_rst");
    chk("post_rst_pred", 16'(is_predict), 16'h0);

    // Branch at 0xFFFF not taken: sequential PC wraps to 0x0000
    step(0, 0, 16'h0, 0, 16'h0, 1, 0, 0, 16'h0009, "wrap_res");
    chk("wrap_redirect", redirect_pc, 16'h0000);
    chk("wrap_flush", 16'(flush), 16'h1);
    idle("wrap_bubble");

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] ipc;
      ipc = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom_range(0, 63));
      step(($urandom_range(0, 4) == 0), ($urandom_range(0, 5) != 0), ipc,
           1'($urandom), pool[$urandom_range(0, 3)],
           1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom),
           pool[$urandom_range(0, 3)], "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
